// File: rtl/mem_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_bridge
// Purpose  : Far end of the mem_mesh io bus. Buffers mesh io writes per port and
//            streams them round-robin to the host; injects host writes as pulses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_io_bridge #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int PORT_W     = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS-1:0]            mem_io_active_out,
    input  logic [PORTS*DATA_WIDTH-1:0] mem_io_data_out,
    output logic [PORTS-1:0]            mem_io_active_in,
    output logic [PORTS*DATA_WIDTH-1:0] mem_io_data_in,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic [PORT_W-1:0]           tx_port,
    output logic [DATA_WIDTH-1:0]       tx_data,
    input  logic                        rx_valid,
    output logic                        rx_ready,
    input  logic [PORT_W-1:0]           rx_port,
    input  logic [DATA_WIDTH-1:0]       rx_data,
    output logic [PORTS-1:0]            ovf,
    input  logic                        ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] c_ptr_one = (AW+1)'(1);

    logic [PORTS-1:0]            fifo_empty, fifo_full, fifo_push, fifo_pop, ovf_set, port_avail;
    logic [DATA_WIDTH-1:0]       port_head [PORTS];
    logic                        stage_load, sel_found;
    logic [PORT_W-1:0]           sel_port;
    logic [DATA_WIDTH-1:0]       sel_data;

    logic                        tx_valid_q, tx_valid_d;
    logic [PORT_W-1:0]           tx_port_q, tx_port_d;
    logic [DATA_WIDTH-1:0]       tx_data_q, tx_data_d;
    logic [PORT_W-1:0]           rr_q, rr_d;
    logic [PORTS-1:0]            ovf_q, ovf_d;
    logic                        rx_ready_q, rx_ready_d;
    logic [PORTS-1:0]            active_in_q, active_in_d;
    logic [PORTS*DATA_WIDTH-1:0] data_in_q, data_in_d;

    generate
        for (genvar p = 0; p < PORTS; p++) begin : g_port
            logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
            logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
            logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
            logic [DATA_WIDTH-1:0] wdata;

            assign wdata          = mem_io_data_out[p*DATA_WIDTH +: DATA_WIDTH];
            assign fifo_empty[p]  = (wr_ptr_q == rd_ptr_q);
            assign fifo_full[p]   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
            // An empty FIFO offers the word arriving this cycle, giving one-cycle latency
            assign port_avail[p]  = ~fifo_empty[p] | mem_io_active_out[p];
            assign port_head[p]   = fifo_empty[p] ? wdata : mem_q[rd_ptr_q[AW-1:0]];
            assign fifo_pop[p]    = stage_load & sel_found & (sel_port == PORT_W'(p));
            assign fifo_push[p]   = mem_io_active_out[p] & (~fifo_full[p] | fifo_pop[p]);
            assign ovf_set[p]     = mem_io_active_out[p] & fifo_full[p] & ~fifo_pop[p];

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    mem_d[i] = mem_q[i];
                end
                if (fifo_push[p]) begin
                    mem_d[wr_ptr_q[AW-1:0]] = wdata;
                    wr_ptr_d = wr_ptr_q + c_ptr_one;
                end
                if (fifo_pop[p]) begin
                    rd_ptr_d = rd_ptr_q + c_ptr_one;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                end
            end

            always_ff @(posedge clk) begin
                mem_q <= mem_d;
            end
        end
    endgenerate

    // Round-robin pick: first available port at or above rr_q, then wrap to the rest
    always_comb begin
        sel_found = 1'b0;
        sel_port  = '0;
        sel_data  = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (!sel_found && port_avail[i] && (i >= int'(rr_q))) begin
                sel_found = 1'b1;
                sel_port  = PORT_W'(i);
                sel_data  = port_head[i];
            end
        end
        for (int i = 0; i < PORTS; i++) begin
            if (!sel_found && port_avail[i] && (i < int'(rr_q))) begin
                sel_found = 1'b1;
                sel_port  = PORT_W'(i);
                sel_data  = port_head[i];
            end
        end
    end

    assign stage_load = ~tx_valid_q | tx_ready;

    always_comb begin
        tx_valid_d  = tx_valid_q;
        tx_port_d   = tx_port_q;
        tx_data_d   = tx_data_q;
        rr_d        = rr_q;
        ovf_d       = (ovf_clr ? '0 : ovf_q) | ovf_set;
        rx_ready_d  = 1'b1;
        active_in_d = '0;
        data_in_d   = '0;
        if (stage_load) begin
            tx_valid_d = sel_found;
            tx_port_d  = sel_port;
            tx_data_d  = sel_data;
            if (sel_found) begin
                rr_d = (int'(sel_port) == PORTS - 1) ? '0 : sel_port + PORT_W'(1);
            end
        end
        // Out-of-range rx_port matches no port, so the beat is silently discarded
        for (int p = 0; p < PORTS; p++) begin
            if (rx_valid && rx_ready_q && (rx_port == PORT_W'(p))) begin
                active_in_d[p]                        = 1'b1;
                data_in_d[p*DATA_WIDTH +: DATA_WIDTH] = rx_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_valid_q  <= 1'b0;
            tx_port_q   <= '0;
            tx_data_q   <= '0;
            rr_q        <= '0;
            ovf_q       <= '0;
            rx_ready_q  <= 1'b0;
            active_in_q <= '0;
            data_in_q   <= '0;
        end else begin
            tx_valid_q  <= tx_valid_d;
            tx_port_q   <= tx_port_d;
            tx_data_q   <= tx_data_d;
            rr_q        <= rr_d;
            ovf_q       <= ovf_d;
            rx_ready_q  <= rx_ready_d;
            active_in_q <= active_in_d;
            data_in_q   <= data_in_d;
        end
    end

    assign tx_valid         = tx_valid_q;
    assign tx_port          = tx_port_q;
    assign tx_data          = tx_data_q;
    assign ovf              = ovf_q;
    assign rx_ready         = rx_ready_q;
    assign mem_io_active_in = active_in_q;
    assign mem_io_data_in   = data_in_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_io_bridge
// Purpose  : Self-checking bench for mem_io_bridge (5 ports, 8-bit data).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_io_bridge;

    localparam int PORTS = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int PW    = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [PORTS-1:0]    act_out;
    logic [PORTS*DW-1:0] dout;
    logic [PORTS-1:0]    act_in;
    logic [PORTS*DW-1:0] din;
    logic                tx_valid, tx_ready;
    logic [PW-1:0]       tx_port;
    logic [DW-1:0]       tx_data;
    logic                rx_valid, rx_ready;
    logic [PW-1:0]       rx_port;
    logic [DW-1:0]       rx_data;
    logic [PORTS-1:0]    ovf;
    logic                ovf_clr;

    int total = 0;
    int bad   = 0;

    mem_io_bridge #(.PORTS(PORTS), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PORT_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_io_active_out(act_out), .mem_io_data_out(dout),
        .mem_io_active_in(act_in), .mem_io_data_in(din),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_port(tx_port), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_port(rx_port), .rx_data(rx_data),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per port plus the visible output stage
    logic [DW-1:0]       mq [PORTS][$];
    int                  m_rr;
    logic                m_valid;
    int                  m_port;
    logic [DW-1:0]       m_data;
    logic [PORTS-1:0]    m_ovf;
    logic                m_rdy;
    logic [PORTS-1:0]    m_ai;
    logic [PORTS*DW-1:0] m_di;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        int            pp;
        bit            load;
        logic [PORTS-1:0] set;
        if (!rst_n) begin
            for (int p = 0; p < PORTS; p++) mq[p].delete();
            m_rr = 0; m_valid = 0; m_port = 0; m_data = '0;
            m_ovf = '0; m_rdy = 0; m_ai = '0; m_di = '0;
            return;
        end
        load = !m_valid || tx_ready;
        pp   = -1;
        if (load) begin
            for (int k = 0; k < PORTS; k++) begin
                int p;
                p = (m_rr + k) % PORTS;
                if (pp < 0 && (mq[p].size() > 0 || act_out[p])) pp = p;
            end
        end
        set = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (act_out[p]) begin
                if (mq[p].size() < DEPTH || p == pp) mq[p].push_back(dout[p*DW +: DW]);
                else set[p] = 1'b1;
            end
        end
        m_ovf = (ovf_clr ? '0 : m_ovf) | set;
        if (load) begin
            if (pp >= 0) begin
                m_valid = 1; m_port = pp; m_data = mq[pp].pop_front();
                m_rr = (pp + 1) % PORTS;
            end else begin
                m_valid = 0; m_port = 0; m_data = '0;
            end
        end
        m_ai = '0;
        m_di = '0;
        if (rx_valid && m_rdy && int'(rx_port) < PORTS) begin
            m_ai[rx_port] = 1'b1;
            m_di[int'(rx_port)*DW +: DW] = rx_data;
        end
        m_rdy = 1;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("tx_valid", 64'(tx_valid), 64'(m_valid));
        chk("tx_port",  64'(tx_port),  64'(m_port));
        chk("tx_data",  64'(tx_data),  64'(m_data));
        chk("ovf",      64'(ovf),      64'(m_ovf));
        chk("rx_ready", 64'(rx_ready), 64'(m_rdy));
        chk("act_in",   64'(act_in),   64'(m_ai));
        chk("data_in",  64'(din),      64'(m_di));
    endtask

    task automatic idle();
        act_out = '0; dout = '0; rx_valid = 0; rx_port = '0; rx_data = '0; ovf_clr = 0;
    endtask

    task automatic pulse(input int p, input logic [DW-1:0] d);
        act_out = '0; dout = '0;
        act_out[p] = 1'b1;
        dout[p*DW +: DW] = d;
    endtask

    typedef struct {
        logic [PORTS-1:0]    act;
        logic [PORTS*DW-1:0] dat;
        logic                rxv;
        logic [PW-1:0]       rxp;
        logic [DW-1:0]       rxd;
        logic                ev;
        logic [PW-1:0]       ep;
        logic [DW-1:0]       ed;
        logic [PORTS-1:0]    eai;
        logic [PORTS*DW-1:0] edi;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [DW-1:0] exp_q [$];
        vecs[0]  = '{5'b01011, 40'h00_13_00_11_10, 0, 3'd0, 8'h00, 1, 3'd0, 8'h10, 5'b0, 40'h0};
        vecs[1]  = '{5'b00000, 40'h0,              0, 3'd0, 8'h00, 1, 3'd1, 8'h11, 5'b0, 40'h0};
        vecs[2]  = '{5'b00000, 40'h0,              0, 3'd0, 8'h00, 1, 3'd3, 8'h13, 5'b0, 40'h0};
        vecs[3]  = '{5'b00000, 40'h0,              0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 5'b0, 40'h0};
        vecs[4]  = '{5'b01001, 40'h00_23_00_00_20, 0, 3'd0, 8'h00, 1, 3'd0, 8'h20, 5'b0, 40'h0};
        vecs[5]  = '{5'b00000, 40'h0,              0, 3'd0, 8'h00, 1, 3'd3, 8'h23, 5'b0, 40'h0};
        vecs[6]  = '{5'b00000, 40'h0,              0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 5'b0, 40'h0};
        vecs[7]  = '{5'b00100, 40'h00_00_A5_00_00, 0, 3'd0, 8'h00, 1, 3'd2, 8'hA5, 5'b0, 40'h0};
        vecs[8]  = '{5'b00000, 40'h0,              0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 5'b0, 40'h0};
        vecs[9]  = '{5'b00000, 40'h0,              1, 3'd1, 8'h3C, 0, 3'd0, 8'h00, 5'b00010, 40'h00_00_00_3C_00};
        vecs[10] = '{5'b00000, 40'h0,              1, 3'd5, 8'hFF, 0, 3'd0, 8'h00, 5'b0, 40'h0};
        vecs[11] = '{5'b00000, 40'h0,              1, 3'd4, 8'h77, 0, 3'd0, 8'h00, 5'b10000, 40'h77_00_00_00_00};
        vecs[12] = '{5'b00000, 40'h0,              0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 5'b0, 40'h0};

        // Reset held with traffic present
        rst_n = 0; tx_ready = 1;
        act_out = '1; dout = 40'hAA_BB_CC_DD_EE; rx_valid = 1; rx_port = 3'd1; rx_data = 8'h55; ovf_clr = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("reset_rx_ready", 64'(rx_ready), 64'd0);
            chk("reset_tx_valid", 64'(tx_valid), 64'd0);
        end
        idle();
        rst_n = 1;
        cyc();
        chk("post_reset_rx_ready", 64'(rx_ready), 64'd1);

        // Table-driven: round-robin, single capture, inbound pulses
        for (int i = 0; i < 13; i++) begin
            act_out = vecs[i].act; dout = vecs[i].dat;
            rx_valid = vecs[i].rxv; rx_port = vecs[i].rxp; rx_data = vecs[i].rxd;
            cyc();
            chk($sformatf("vec%0d_tx_valid", i), 64'(tx_valid), 64'(vecs[i].ev));
            chk($sformatf("vec%0d_tx_port", i),  64'(tx_port),  64'(vecs[i].ep));
            chk($sformatf("vec%0d_tx_data", i),  64'(tx_data),  64'(vecs[i].ed));
            chk($sformatf("vec%0d_act_in", i),   64'(act_in),   64'(vecs[i].eai));
            chk($sformatf("vec%0d_data_in", i),  64'(din),      64'(vecs[i].edi));
        end
        idle();

        // Backpressure: stage plus four FIFO slots hold 0x51..0x55, 0x56 overflows
        tx_ready = 0;
        for (int i = 0; i < 6; i++) begin
            pulse(1, 8'h51 + 8'(i));
            cyc();
            chk("bp_held_data", 64'(tx_data), 64'h51);
        end
        chk("bp_ovf_set", 64'(ovf), 64'b00010);
        idle();
        cyc();
        chk("bp_still_held", 64'(tx_data), 64'h51);
        tx_ready = 1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("bp_drain_order", 64'(tx_data), 64'(8'h52 + 8'(k)));
        end
        cyc();
        chk("bp_drain_empty", 64'(tx_valid), 64'd0);
        chk("bp_ovf_sticky", 64'(ovf), 64'b00010);
        ovf_clr = 1;
        cyc();
        chk("ovf_cleared", 64'(ovf), 64'd0);
        ovf_clr = 0;

        // Clear concurrent with a new overflow keeps the bit set
        tx_ready = 0;
        for (int i = 0; i < 7; i++) begin
            pulse(1, 8'h61 + 8'(i));
            ovf_clr = (i == 6);
            cyc();
        end
        chk("clr_vs_set", 64'(ovf), 64'b00010);
        idle();
        ovf_clr = 1;
        cyc();
        chk("clr_alone", 64'(ovf), 64'd0);
        ovf_clr = 0;

        // Full FIFO push with same-cycle pop: accepted, no overflow
        tx_ready = 1;
        pulse(1, 8'h6A);
        cyc();
        chk("fullpop_ovf", 64'(ovf), 64'd0);
        chk("fullpop_data", 64'(tx_data), 64'h62);
        idle();
        exp_q = '{8'h63, 8'h64, 8'h65, 8'h6A};
        foreach (exp_q[k]) begin
            cyc();
            chk("fullpop_order", 64'(tx_data), 64'(exp_q[k]));
        end
        cyc();
        chk("fullpop_empty", 64'(tx_valid), 64'd0);

        // Randomized traffic against the model, with a mid-run reset
        for (int i = 0; i < 3000; i++) begin
            rst_n = !(i >= 1500 && i < 1502);
            act_out = 5'($urandom_range(0, 31) & $urandom_range(0, 31));
            for (int p = 0; p < PORTS; p++) dout[p*DW +: DW] = act_out[p] ? 8'($urandom) : 8'h00;
            tx_ready = ((i % 300) < 80) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            rx_valid = 1'($urandom);
            rx_port  = 3'($urandom_range(0, 7));
            rx_data  = 8'($urandom);
            ovf_clr  = ($urandom_range(0, 40) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
